imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_pkg.sv | 16 +
 rtl/imem_boot_ctrl_byte_packer.sv | 31 +++
 rtl/imem_boot_ctrl.sv | 121 ++++++++++++
 tb/tb_imem_boot_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// Holds the FSM state encoding plus the default address and instruction widths.
package imem_boot_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Little-endian word assembler: each accepted byte lands in lane byte_count.
// word_ready flags the cycle in which the fourth byte of a word is accepted.
module byte_packer
  import imem_boot_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  logic [1:0]         r_cnt;
  logic [INSTR_W-1:0] r_word;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (shift_en) begin
      r_word[{r_cnt, 3'b000} +: 8] <= byte_in;
      r_cnt                        <= r_cnt + 2'd1;
    end
  end

  assign word       = r_word;
  assign word_ready = shift_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams bytes into 32-bit words, writes them to instruction
// memory, and holds the core in reset until a complete program is present.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no load since reset; memory address follows the core PC
// ST_RECV  | accepting bytes for the current word; idle timer running
// ST_WRITE | one-cycle write strobe of the assembled word
// ST_DONE  | program loaded; core released from reset
// ST_ERROR | load aborted on idle timeout; core held until next start
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  load_len_m1,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  input  logic [ADDR_W-1:0]  core_pc_addr,
  output logic               mem_load_en,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [INSTR_W-1:0] mem_load_inst,
  output logic               core_rst_n,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  boot_state_e       r_state;
  boot_state_e       w_next_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_xfer;
  logic              w_start_ok;
  logic              w_word_ready;
  logic              w_tmo_hit;
  logic              w_last_word;

  assign w_xfer      = byte_valid && byte_ready;
  assign w_start_ok  = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  // Down-counter: the stall that would take it past 1 is the TIMEOUT_CYCLES-th.
  assign w_tmo_hit   = (r_tmo == TMO_W'(1));
  assign w_last_word = (r_idx == r_len);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_start_ok),
    .shift_en   (w_xfer),
    .byte_in    (byte_data),
    .word       (mem_load_inst),
    .word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_next_state = ST_RECV;
      ST_RECV: begin
        if (w_word_ready)            w_next_state = ST_WRITE;
        else if (!w_xfer && w_tmo_hit) w_next_state = ST_ERROR;
      end
      ST_WRITE: w_next_state = w_last_word ? ST_DONE : ST_RECV;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready  = (r_state == ST_RECV);
    mem_load_en = (r_state == ST_WRITE);
    mem_address = (r_state inside {ST_RECV, ST_WRITE}) ? r_idx : core_pc_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len <= '0;
      r_idx <= '0;
      r_tmo <= TMO_LOAD;
    end else if (w_start_ok) begin
      r_len <= load_len_m1;
      r_idx <= '0;
      r_tmo <= TMO_LOAD;
    end else if (r_state == ST_RECV) begin
      if (w_xfer)          r_tmo <= TMO_LOAD;
      else if (!w_tmo_hit) r_tmo <= r_tmo - TMO_W'(1);
    end else if (r_state == ST_WRITE) begin
      r_tmo <= TMO_LOAD;
      // Index stops at the last word so a full 256-word load never wraps.
      if (!w_last_word) r_idx <= r_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      busy       <= (w_next_state inside {ST_RECV, ST_WRITE});
      done       <= (w_next_state == ST_DONE);
      error      <= (w_next_state == ST_ERROR);
      core_rst_n <= (w_next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: reset, two-word load, full load, timeout,
// back-pressure with an ignored start, and reset in the middle of a load.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  load_len_m1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [7:0]  core_pc_addr;
  logic        mem_load_en;
  logic [7:0]  mem_address;
  logic [31:0] mem_load_inst;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int n_stuck  = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_boot_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .load_len_m1   (load_len_m1),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .core_pc_addr  (core_pc_addr),
    .mem_load_en   (mem_load_en),
    .mem_address   (mem_address),
    .mem_load_inst (mem_load_inst),
    .core_rst_n    (core_rst_n),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_load_en === 1'b1) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_load_inst);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    n_stuck = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1;
    load_len_m1 = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) n_stuck++;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      send_byte(b);
    end
  endtask

  task automatic wait_end(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1 || error === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    load_len_m1 = 8'h00;
    core_pc_addr = 8'h5A;
    repeat (2) @(negedge clk);
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    checks++; if (mem_load_en !== 1'b0) begin failures++; $display("FAIL reset_mem_load_en got=%b exp=0", mem_load_en); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready got=%b exp=0", byte_ready); end
    checks++; if (mem_load_inst !== 32'h0) begin failures++; $display("FAIL reset_mem_load_inst got=%h exp=00000000", mem_load_inst); end
    checks++; if (mem_address !== 8'h5A) begin failures++; $display("FAIL reset_addr_pass got=%h exp=5a", mem_address); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL idle_after_reset got busy=%b core_rst_n=%b exp 0/0", busy, core_rst_n); end
    clear_log();
  endtask

  task automatic test_two_word();
    bit ok;
    logic [7:0] bytes_in [8];
    bytes_in = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_log();
    do_start(8'd1);
    checks++; if (busy !== 1'b1 || core_rst_n !== 1'b0) begin failures++; $display("FAIL two_word_enter got busy=%b core_rst_n=%b exp 1/0", busy, core_rst_n); end
    for (int i = 0; i < 8; i++) send_byte(bytes_in[i]);
    wait_end(ok);
    checks++; if (!ok || n_stuck != 0) begin failures++; $display("FAIL two_word_progress got ok=%0d stuck=%0d exp 1/0", ok, n_stuck); end
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL two_word_strobes got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL two_word_w0 got=%h@%h exp=deadbeef@00", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h12345678) begin failures++; $display("FAIL two_word_w1 got=%h@%h exp=12345678@01", wr_data[1], wr_addr[1]); end
    end
    checks++; if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL two_word_done got done=%b core_rst_n=%b busy=%b exp 1/1/0", done, core_rst_n, busy); end
  endtask

  task automatic test_full_load();
    bit ok;
    int bad;
    logic [31:0] w;
    clear_log();
    do_start(8'd255);
    for (int i = 0; i < 256; i++) begin
      w = {24'hDEADBE, 8'(i)};
      send_word(w);
    end
    wait_end(ok);
    checks++; if (!ok || n_stuck != 0) begin failures++; $display("FAIL full_progress got ok=%0d stuck=%0d exp 1/0", ok, n_stuck); end
    checks++; if (wr_addr.size() != 256) begin failures++; $display("FAIL full_strobes got=%0d exp=256", wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {24'hDEADBE, 8'(i)}) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL full_contents got bad_words=%0d exp=0", bad); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL full_done got done=%b error=%b exp 1/0", done, error); end
    core_pc_addr = 8'h10;
    #1;
    checks++; if (mem_address !== 8'h10) begin failures++; $display("FAIL full_pc_pass got=%h exp=10", mem_address); end
  endtask

  task automatic test_timeout();
    apply_reset();
    do_start(8'd3);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (15) @(negedge clk);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_early got error=%b busy=%b exp 0/1", error, busy); end
    @(negedge clk);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_hit got error=%b busy=%b exp 1/0", error, busy); end
    checks++; if (core_rst_n !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL timeout_hold got core_rst_n=%b done=%b exp 0/0", core_rst_n, done); end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL timeout_no_strobe got=%0d exp=0", wr_addr.size()); end
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", error); end
    do_start(8'd0);
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL timeout_restart got busy=%b error=%b exp 1/0", busy, error); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    logic [31:0] words [3];
    logic [7:0] b;
    words = '{32'hA1B2C3D4, 32'h01020304, 32'hCAFEF00D};
    apply_reset();
    do_start(8'd2);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        send_byte(b);
        @(negedge clk);
        if (i == 0 && k == 1) begin
          start = 1'b1;
          load_len_m1 = 8'd0;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    wait_end(ok);
    checks++; if (!ok || n_stuck != 0) begin failures++; $display("FAIL b2b_progress got ok=%0d stuck=%0d exp 1/0", ok, n_stuck); end
    checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL b2b_strobes got=%0d exp=3", wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 3; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== words[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_contents got bad_words=%0d exp=0", bad); end
    checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin failures++; $display("FAIL b2b_done got done=%b core_rst_n=%b exp 1/1", done, core_rst_n); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w;
    apply_reset();
    core_pc_addr = 8'h33;
    do_start(8'd7);
    for (int i = 0; i < 3; i++) begin
      w = {8'h50, 8'h40, 8'h30, 8'(i)};
      send_word(w);
    end
    @(negedge clk);
    checks++; if (wr_addr.size() != 3 || n_stuck != 0) begin failures++; $display("FAIL midrst_pre got strobes=%0d stuck=%0d exp 3/0", wr_addr.size(), n_stuck); end
    send_byte(8'h11);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h22;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL midrst_no_strobe got=%0d exp=3", wr_addr.size()); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL midrst_flags got busy=%b done=%b error=%b exp 0/0/0", busy, done, error); end
    checks++; if (core_rst_n !== 1'b0 || byte_ready !== 1'b0) begin failures++; $display("FAIL midrst_hold got core_rst_n=%b byte_ready=%b exp 0/0", core_rst_n, byte_ready); end
    checks++; if (mem_address !== 8'h33) begin failures++; $display("FAIL midrst_pc_pass got=%h exp=33", mem_address); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two_word();
    test_full_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
